// File: rtl/xcorr_peak_finder_pkg.sv
// Purpose: shared constants, types and lag conversion for the xcorr peak finder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xcorr_peak_finder_pkg;

  localparam int RES_W     = 32;
  localparam int LAG_W     = 6;
  localparam int MAX_LAG   = 31;
  localparam int NUM_LAGS  = 2 * MAX_LAG + 1;
  localparam int IDX_W     = $clog2(NUM_LAGS);
  localparam int AVG_LOG2  = 2;
  localparam int AVG_DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W     = LAG_W + AVG_LOG2;

  typedef logic        [IDX_W-1:0] idx_t;
  typedef logic signed [LAG_W-1:0] lag_t;
  typedef logic signed [RES_W-1:0] res_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  localparam res_t MIN_PEAK = '0;
  localparam idx_t LAST_IDX = idx_t'(NUM_LAGS - 1);

  // One accepted-frame lag handed from the peak tracker to the averager.
  typedef struct packed {
    logic vld;
    lag_t lag;
  } lag_push_t;

  // Frame index k corresponds to lag k - MAX_LAG.
  function automatic lag_t idx_to_lag(input idx_t k);
    return lag_t'($signed({2'b00, k}) - $signed((IDX_W + 2)'(MAX_LAG)));
  endfunction

endpackage

// File: rtl/xcorr_peak_finder_lag_avg_filter.sv
// Purpose: moving average of the last AVG_DEPTH accepted lags (zero-filled history).
// Latency: lag_avg/avg_valid registered 1 cycle after a push.
// Backpressure: none; accepts a push every cycle.
// Ports: clk, rst_n (async low), clear (sync flush), push (vld+lag),
//        lag_avg (floor of mean), avg_valid (1-cycle pulse on update).
module lag_avg_filter
  import xcorr_peak_finder_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear,
  input  lag_push_t push,
  output lag_t      lag_avg,
  output logic      avg_valid
);

  lag_t hist [AVG_DEPTH];
  sum_t sum;
  sum_t new_ext;
  sum_t old_ext;
  sum_t sum_next;

  // Running sum avoids re-adding the whole window: add newest, drop oldest.
  always_comb begin
    new_ext  = {{AVG_LOG2{push.lag[LAG_W-1]}}, push.lag};
    old_ext  = {{AVG_LOG2{hist[AVG_DEPTH-1][LAG_W-1]}}, hist[AVG_DEPTH-1]};
    sum_next = sum + new_ext - old_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AVG_DEPTH; i++) hist[i] <= '0;
      sum       <= '0;
      lag_avg   <= '0;
      avg_valid <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < AVG_DEPTH; i++) hist[i] <= '0;
      sum       <= '0;
      lag_avg   <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (push.vld) begin
        for (int i = AVG_DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0]   <= push.lag;
        sum       <= sum_next;
        // Arithmetic shift floors toward -inf for negative sums.
        lag_avg   <= lag_t'(sum_next >>> AVG_LOG2);
        avg_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/xcorr_peak_finder.sv
// Purpose: argmax over a serial frame of NUM_LAGS correlation results, plus lag averaging.
// Latency: lag_valid 1 cycle after the last result, avg_valid 2 cycles after it.
// Backpressure: none; one result per cycle, arbitrary gaps between results.
// Ports: clk, rst_n (async low), clear (sync flush, top priority), sof, res_valid, res_data;
//        lag_diff, peak_value, peak_ok, lag_valid, lag_avg, avg_valid, frame_err.
module xcorr_peak_finder
  import xcorr_peak_finder_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    sof,
  input  logic                    res_valid,
  input  logic signed [RES_W-1:0] res_data,
  output logic signed [LAG_W-1:0] lag_diff,
  output logic signed [RES_W-1:0] peak_value,
  output logic                    peak_ok,
  output logic                    lag_valid,
  output logic signed [LAG_W-1:0] lag_avg,
  output logic                    avg_valid,
  output logic                    frame_err
);

  idx_t      idx;
  res_t      run_max;
  idx_t      run_arg;
  lag_push_t push;

  logic first;
  logic last;
  logic abort;
  res_t cand_max;
  idx_t cand_arg;
  logic cand_ok;
  lag_t cand_lag;

  always_comb begin
    // A sample arriving with sof always starts a new frame, even at the old frame's last slot.
    first    = res_valid && (sof || (idx == '0));
    last     = res_valid && !sof && (idx == LAST_IDX);
    abort    = sof && (idx != '0);
    cand_max = run_max;
    cand_arg = run_arg;
    if (first) begin
      cand_max = res_data;
      cand_arg = '0;
    end else if (res_valid && (res_data > run_max)) begin
      // Strict compare: ties keep the earlier, more negative lag.
      cand_max = res_data;
      cand_arg = idx;
    end
    cand_ok  = cand_max > MIN_PEAK;
    cand_lag = idx_to_lag(cand_arg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      run_max    <= '0;
      run_arg    <= '0;
      lag_diff   <= '0;
      peak_value <= '0;
      peak_ok    <= 1'b0;
      lag_valid  <= 1'b0;
      frame_err  <= 1'b0;
      push       <= '0;
    end else if (clear) begin
      idx        <= '0;
      run_max    <= '0;
      run_arg    <= '0;
      lag_diff   <= '0;
      peak_value <= '0;
      peak_ok    <= 1'b0;
      lag_valid  <= 1'b0;
      frame_err  <= 1'b0;
      push       <= '0;
    end else begin
      lag_valid <= 1'b0;
      frame_err <= abort;
      push      <= '0;
      if (res_valid) begin
        run_max <= cand_max;
        run_arg <= cand_arg;
        if (last) begin
          idx        <= '0;
          lag_valid  <= 1'b1;
          peak_value <= cand_max;
          peak_ok    <= cand_ok;
          if (cand_ok) lag_diff <= cand_lag;
          // Rejected frames never reach the averager.
          push.vld   <= cand_ok;
          push.lag   <= cand_lag;
        end else begin
          idx <= first ? idx_t'(1) : idx + idx_t'(1);
        end
      end else if (sof) begin
        idx <= '0;
      end
    end
  end

  lag_avg_filter u_avg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push     (push),
    .lag_avg  (lag_avg),
    .avg_valid(avg_valid)
  );

endmodule
